// File: rtl/btn_pkg.sv
// btn_pkg: shared constants for the push-button peripheral.
// Register word offsets, channel count and reset values.
package btn_pkg;

    localparam int NUM_BTN = 5;

    localparam logic [1:0] OFS_STATUS = 2'd0;
    localparam logic [1:0] OFS_PRESS  = 2'd1;
    localparam logic [1:0] OFS_MASK   = 2'd2;
    localparam logic [1:0] OFS_RSVD   = 2'd3;

    localparam logic [NUM_BTN-1:0] MASK_RESET = 5'b11111;

    // Zero-extend a per-button field to a bus word.
    function automatic logic [31:0] to_word(
        input logic [NUM_BTN-1:0] v
    );
        return {{(32 - NUM_BTN){1'b0}}, v};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel.
// Two-flop synchroniser followed by a stable-count debouncer.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchroniser: bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles of disagreement; flip deb once stable long enough.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign out = deb_q;

endmodule

// File: rtl/btn_ctrl.sv
// btn_ctrl: memory-mapped push-button peripheral.
// Debounced levels, masked sticky press events (W1C) and an irq summary.
module btn_ctrl
    import btn_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_8000,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          CNT_W           = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic        enabler,
    input  logic        write_enabler,
    input  logic [31:0] addr,
    input  logic [3:0]  select,
    input  logic [31:0] data_input,
    output logic [31:0] data_output,
    output logic        irq
);

    logic [NUM_BTN-1:0] deb;
    logic [NUM_BTN-1:0] deb_dly_q;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] set_ev;
    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] press_d;
    logic [NUM_BTN-1:0] mask_q;
    logic [NUM_BTN-1:0] mask_d;
    logic               irq_q;
    logic               hit;
    logic [1:0]         ofs;
    logic               wr_en;
    logic               rd_en;
    logic               unused_ok;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .in  (btn[i]),
            .out (deb[i])
        );
    end

    assign hit    = (addr[31:4] == BASE_ADDR[31:4]);
    assign ofs    = addr[3:2];
    assign wr_en  = enabler & write_enabler & hit & select[0];
    assign rd_en  = enabler & ~write_enabler & hit;
    assign rise   = deb & ~deb_dly_q;
    assign set_ev = rise & mask_q;

    // Byte lanes above lane 0 and the low address bits carry nothing here.
    assign unused_ok = ^{addr[1:0], select[3:1], data_input[31:NUM_BTN]};

    // Register next-state: W1C / mask load, then a new press always wins.
    always_comb begin
        press_d = press_q;
        mask_d  = mask_q;
        if (wr_en && ofs == OFS_PRESS) begin
            press_d = press_q & ~data_input[NUM_BTN-1:0];
        end
        if (wr_en && ofs == OFS_MASK) begin
            mask_d = data_input[NUM_BTN-1:0];
        end
        press_d = press_d | set_ev;
    end

    // Edge-detect delay, sticky press, mask and irq registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_dly_q <= '0;
            press_q   <= '0;
            mask_q    <= MASK_RESET;
            irq_q     <= 1'b0;
        end else begin
            deb_dly_q <= deb;
            press_q   <= press_d;
            mask_q    <= mask_d;
            irq_q     <= |press_d;
        end
    end

    // Combinational read mux; idle or missed bus reads return zero.
    always_comb begin
        data_output = 32'h0;
        if (rd_en) begin
            unique case (ofs)
                OFS_STATUS: data_output = to_word(deb);
                OFS_PRESS:  data_output = to_word(press_q);
                OFS_MASK:   data_output = to_word(mask_q);
                OFS_RSVD:   data_output = 32'h0;
                default:    data_output = 32'h0;
            endcase
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_btn_ctrl.sv
// tb_btn_ctrl: directed bench for btn_ctrl with a read scoreboard.
// Stimulus queues expected read data/irq; a monitor pops and compares.
module tb_btn_ctrl;

    localparam logic [31:0] A_STATUS = 32'h0000_8000;
    localparam logic [31:0] A_PRESS  = 32'h0000_8004;
    localparam logic [31:0] A_MASK   = 32'h0000_8008;
    localparam logic [31:0] A_RSVD   = 32'h0000_800C;
    localparam logic [31:0] A_MISS   = 32'h0000_9004;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  btn;
    logic        enabler;
    logic        write_enabler;
    logic [31:0] addr;
    logic [3:0]  select;
    logic [31:0] data_input;
    logic [31:0] data_output;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    event rd_ev;
    int   n_cmp = 0;
    int   n_err = 0;

    btn_ctrl #(
        .BASE_ADDR       (32'h0000_8000),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn),
        .enabler       (enabler),
        .write_enabler (write_enabler),
        .addr          (addr),
        .select        (select),
        .data_input    (data_input),
        .data_output   (data_output),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    // Monitor: each bus read strobe pops one expectation.
    always begin
        @(rd_ev);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard-empty: read with no expectation");
        end else begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            if (!(enabler && !write_enabler) || data_output !== e.data) begin
                n_err++;
                $display("FAIL %s data: got %h expected %h", e.name,
                         data_output, e.data);
            end
            n_cmp++;
            if (irq !== e.irq) begin
                n_err++;
                $display("FAIL %s irq: got %b expected %b", e.name,
                         irq, e.irq);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d,
                      input logic i, input string nm);
        exp_t e;
        e.name = nm;
        e.data = d;
        e.irq  = i;
        sb_q.push_back(e);
        addr          = a;
        select        = 4'b0000;
        write_enabler = 1'b0;
        enabler       = 1'b1;
        #1;
        ->rd_ev;
        #1;
        enabler = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] sel);
        addr          = a;
        data_input    = d;
        select        = sel;
        write_enabler = 1'b1;
        enabler       = 1'b1;
        @(posedge clk);
        #1;
        enabler       = 1'b0;
        write_enabler = 1'b0;
        select        = 4'b0000;
        data_input    = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        btn           = 5'b0;
        enabler       = 1'b0;
        write_enabler = 1'b0;
        addr          = 32'h0;
        select        = 4'b0;
        data_input    = 32'h0;
        tick(3);
        rst = 1'b0;

        // reset values
        rd(A_STATUS, 32'h00, 1'b0, "rst_status");
        rd(A_PRESS,  32'h00, 1'b0, "rst_press");
        rd(A_MASK,   32'h1F, 1'b0, "rst_mask");
        tick(1);
        rd(A_RSVD,   32'h00, 1'b0, "rst_rsvd");

        // btn[2] held: STATUS at 6 edges, PRESS/irq at 7
        btn[2] = 1'b1;
        tick(5);
        rd(A_STATUS, 32'h00, 1'b0, "b2_status_e5");
        tick(1);
        rd(A_STATUS, 32'h04, 1'b0, "b2_status_e6");
        rd(A_PRESS,  32'h00, 1'b0, "b2_press_e6");
        tick(1);
        rd(A_PRESS,  32'h04, 1'b1, "b2_press_e7");
        rd(A_MISS,   32'h00, 1'b1, "miss_addr");
        btn[2] = 1'b0;
        tick(8);
        rd(A_STATUS, 32'h00, 1'b1, "b2_release_status");
        rd(A_PRESS,  32'h04, 1'b1, "b2_release_press");

        // 3-cycle glitch on btn[0] is rejected
        btn[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) btn[0] = 1'b0;
            rd(A_STATUS, 32'h00, 1'b1, "glitch_status");
            rd(A_PRESS,  32'h04, 1'b1, "glitch_press");
            tick(1);
        end

        // 5-cycle pulse on btn[0] is accepted
        btn[0] = 1'b1;
        tick(5);
        btn[0] = 1'b0;
        tick(12);
        rd(A_PRESS,  32'h05, 1'b1, "pulse5_press");
        rd(A_STATUS, 32'h00, 1'b1, "pulse5_status");

        // W1C behaviour and lane/target qualification
        wr(A_PRESS, 32'h04, 4'b0001);
        rd(A_PRESS, 32'h01, 1'b1, "w1c_bit2");
        wr(A_PRESS, 32'h01, 4'b0010);
        rd(A_PRESS, 32'h01, 1'b1, "w1c_lane1_ignored");
        wr(A_STATUS, 32'h1F, 4'b0001);
        rd(A_PRESS,  32'h01, 1'b1, "status_wr_press");
        rd(A_STATUS, 32'h00, 1'b1, "status_wr_ignored");
        wr(A_PRESS, 32'h01, 4'b0001);
        rd(A_PRESS, 32'h00, 1'b0, "w1c_bit0");

        // MASK gates new presses only
        wr(A_MASK, 32'h1E, 4'b0001);
        rd(A_MASK, 32'h1E, 1'b0, "mask_load");
        btn = 5'b00001;
        tick(8);
        rd(A_STATUS, 32'h01, 1'b0, "masked_status");
        rd(A_PRESS,  32'h00, 1'b0, "masked_press");
        btn = 5'b00011;
        tick(8);
        rd(A_STATUS, 32'h03, 1'b1, "unmasked_status");
        rd(A_PRESS,  32'h02, 1'b1, "unmasked_press");
        wr(A_MASK, 32'h00, 4'b0001);
        rd(A_PRESS, 32'h02, 1'b1, "mask_clr_keeps_press");
        rd(A_MASK,  32'h00, 1'b1, "mask_clr");
        btn = 5'b00000;
        tick(8);
        rd(A_STATUS, 32'h00, 1'b1, "release_all");
        wr(A_PRESS, 32'h1F, 4'b0001);
        wr(A_MASK,  32'h1F, 4'b0001);
        rd(A_PRESS, 32'h00, 1'b0, "clear_all");
        rd(A_MASK,  32'h1F, 1'b0, "mask_restore");

        // W1C on the same edge that PRESS[3] sets: set wins
        btn[3] = 1'b1;
        tick(6);
        wr(A_PRESS, 32'h08, 4'b0001);
        rd(A_PRESS, 32'h08, 1'b1, "set_beats_w1c");
        btn[3] = 1'b0;
        tick(8);
        rd(A_PRESS,  32'h08, 1'b1, "press3_sticky");

        // reset mid-debounce of btn[4]
        wr(A_MASK, 32'h18, 4'b0001);
        btn[4] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        rd(A_STATUS, 32'h00, 1'b0, "midrst_status");
        rd(A_PRESS,  32'h00, 1'b0, "midrst_press");
        rd(A_MASK,   32'h1F, 1'b0, "midrst_mask");
        rst = 1'b0;
        tick(6);
        rd(A_STATUS, 32'h10, 1'b0, "postrst_status_e6");
        rd(A_PRESS,  32'h00, 1'b0, "postrst_press_e6");
        tick(1);
        rd(A_PRESS,  32'h10, 1'b1, "postrst_press_e7");

        tick(2);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard-drain: %0d left, expected 0",
                     sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
